comp_seq_gen: RTL and testbench
===============================

Name: comp_seq_gen

Overview:
Parametrised successor to the fixed 16-group challenge-to-TERO sequencer. It accepts a challenge and decodes it, sequentially, into a group pair (i,j). It then streams every TERO index needed for that pair over a valid/ready handshake to the frequency-counter front-end. Group, batch and loops-per-group counts are generic; invalid challenges are flagged explicitly and never silently ignored.

Parameters:
NUM_GROUPS, 16, number of TERO groups G; valid pairs P = G*(G-1)/2
LOOPS_PER_GROUP, 8, loops per group per batch L
NUM_BATCHES, 10, batches B; batch stride = G*L
CH_W, 8, challenge width; must satisfy 2^CH_W >= P
IDX_W, 12, TERO index width; must satisfy 2^IDX_W >= G*L*B (elaboration-time assertion)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
challenge_in  in  CH_W  challenge; captured when start is accepted
tero_idx  out  IDX_W  TERO index to evaluate
tero_valid  out  1  tero_idx valid
tero_ready  in  1  consumer accepts tero_idx
tero_last  out  1  marks final index of the sequence
phase  out  1  0 = index belongs to group i, 1 = group j
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the final beat is accepted
err  out  1  one-cycle pulse when the challenge is out of range

Behaviour:
- Reset (async): state=IDLE. All of these are 0: tero_idx, tero_valid, tero_last, phase, busy, done, err. Internal i, j, k, l and remainder are also cleared. Reset mid-sequence aborts with no done pulse.
- IDLE:
  - start=1 with challenge_in >= P: err=1 for the next cycle, then stay in IDLE; no beats are emitted.
  - start=1 with a valid challenge: latch rem=challenge_in, i=0; go to DECODE.
- DECODE, one comparison per cycle:
  - If rem < G-1-i: j = i+1+rem; go to EMIT with k=0, l=0, phase=0.
  - Otherwise: rem -= G-1-i and i++.
  - DECODE therefore lasts i_final+1 cycles.
  - Mapping is lexicographic. For G=16: 0->(0,1), 14->(0,15), 15->(1,2), 119->(14,15).
- EMIT:
  - tero_idx = g*L + k*(G*L) + l, where g=i when phase=0 and g=j when phase=1. Computed at full width, then truncated to IDX_W.
  - tero_valid is registered. tero_idx, phase and tero_last are held stable while tero_valid=1 and tero_ready=0.
  - Counters advance only on tero_valid&&tero_ready. k (0..B-1) is the inner counter; l (0..L-1) is the outer counter. On k and l both wrapping in phase 0, set phase=1. On k and l both wrapping in phase 1, the beat is last.
  - Sequence length is 2*L*B beats (160 by default). A new beat is presented in the cycle after each acceptance, so full throughput is 1 beat/cycle with tero_ready=1.
  - tero_last=1 only on the final beat. After it is accepted: tero_valid=0, and done=1 in the following cycle (state IDLE).
- done/err cycle: the state is IDLE, so a start in that same cycle is accepted.
- start while busy is ignored; challenge_in is not re-sampled.
- busy is low in IDLE, including the done/err cycle.

Optional Feature:
COMP_SEQ_INTERLEAVE_EN
- Defined: beats alternate i, j, i, j… for each (k,l) point. The beat order is i(k,l), j(k,l), then the counters advance. phase toggles on every accepted beat. tero_last is on j(B-1,L-1). Total length is unchanged.
- Undefined: all i beats come first, then all j beats, as described above.

Decomposition:
- comp_seq_pkg holds:
  - the state enum (IDLE, DECODE, EMIT);
  - derived constants P, BATCH_STRIDE=G*L, TOTAL_BEATS=2*L*B;
  - a clog2 helper for counter widths.
- One sub-module, comp_pair_decode. It implements the sequential challenge->(i,j) decoder with a start/valid pulse interface and a range check (err).
- comp_seq_gen instantiates comp_pair_decode and adds the emit counters and handshake.

Test Plan:
- Challenge 14, tero_ready=1 -> DECODE 1 cycle, then 160 beats:
  - phase 0: 0,128,…,1152, then 1,129,…, ending at 7,…,1159;
  - phase 1: 120,248,…,1272, then 121,…, ending at 1279 with tero_last=1;
  - done pulses once after the last beat.
- Challenge 15 -> pair (1,2), DECODE 2 cycles; first beat 8; first phase-1 beat 16.
- Challenge 120 -> err=1 for one cycle; tero_valid never asserts; busy low throughout.
- Challenge 0, tero_ready held low 3 cycles on beat 5 -> tero_idx stays 512 with valid high; the sequence resumes with no beat lost or duplicated.
- Reset asserted on beat 40 -> all outputs 0 immediately with no done pulse; a new start with challenge 119 then yields (14,15), first beat 112.
- COMP_SEQ_INTERLEAVE_EN defined, challenge 14 -> sequence 0,120,128,248,…, with phase toggling every beat, last beat 1279.

Source files
------------

// File: rtl/comp_seq_gen_pkg.sv
// Shared state type, default geometry and sizing helpers for the comp_seq_gen sequencer.
package comp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EMIT   = 2'd2
    } state_t;

    function automatic int num_pairs(input int groups);
        return groups * (groups - 1) / 2;
    endfunction

    function automatic int batch_stride(input int groups, input int loops);
        return groups * loops;
    endfunction

    function automatic int total_beats(input int loops, input int batches);
        return 2 * loops * batches;
    endfunction

    // Counter width for values 0..value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        int w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    function automatic int unsigned tero_index(input int unsigned g, input int unsigned k,
                                               input int unsigned l, input int unsigned stride,
                                               input int unsigned loops);
        return g * loops + k * stride + l;
    endfunction

    localparam int P            = num_pairs(16);
    localparam int BATCH_STRIDE = batch_stride(16, 8);
    localparam int TOTAL_BEATS  = total_beats(8, 10);

endpackage

// File: rtl/comp_seq_gen_if.sv
// Request/stream bundle between a controller and comp_seq_gen; slave is the sequencer side.
interface comp_seq_gen_if #(
    parameter int CH_W  = 8,
    parameter int IDX_W = 12
);
    logic             start;
    logic [CH_W-1:0]  challenge_in;
    logic [IDX_W-1:0] tero_idx;
    logic             tero_valid;
    logic             tero_ready;
    logic             tero_last;
    logic             phase;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, challenge_in, tero_ready,
        input  tero_idx, tero_valid, tero_last, phase, busy, done, err
    );

    modport slave (
        input  start, challenge_in, tero_ready,
        output tero_idx, tero_valid, tero_last, phase, busy, done, err
    );
endinterface

// File: rtl/comp_seq_gen_pair_decode.sv
// Sequential challenge -> lexicographic group pair (i,j) decoder, one subtraction per step.
module comp_pair_decode
    import comp_seq_pkg::*;
#(
    parameter int NUM_GROUPS = 16,
    parameter int CH_W       = 8,
    parameter int G_W        = clog2_min1(NUM_GROUPS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic [CH_W-1:0] i_challenge,
    input  logic            i_step,
    output logic            o_load,
    output logic            o_hit,
    output logic            o_err,
    output logic [G_W-1:0]  o_i,
    output logic [G_W-1:0]  o_j
);
    localparam int N_PAIRS = num_pairs(NUM_GROUPS);

    logic [G_W-1:0]  r_i;
    logic [CH_W-1:0] r_rem;
    logic            r_err;
    logic [31:0]     w_span;
    logic            w_in_range;

    // Pairs remaining in row i: (i,i+1) .. (i,G-1).
    assign w_span     = 32'(NUM_GROUPS - 1) - 32'(r_i);
    assign w_in_range = 32'(i_challenge) < 32'(N_PAIRS);
    assign o_load     = i_start && w_in_range;
    assign o_hit      = i_step && (32'(r_rem) < w_span);
    assign o_err      = r_err;
    assign o_i        = r_i;
    assign o_j        = G_W'(32'(r_i) + 32'(r_rem) + 32'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i   <= '0;
            r_rem <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= i_start && !w_in_range;
            if (o_load) begin
                r_i   <= '0;
                r_rem <= i_challenge;
            end else if (i_step && !o_hit) begin
                r_i   <= r_i + G_W'(1);
                r_rem <= r_rem - CH_W'(w_span);
            end
        end
    end
endmodule

// File: rtl/comp_seq_gen.sv
// Challenge -> TERO index streamer: decodes a pair and emits 2*L*B indices over valid/ready.
// Optional macro COMP_SEQ_INTERLEAVE_EN: emit i/j beats alternately per (k,l) point.
module comp_seq_gen
    import comp_seq_pkg::*;
#(
    parameter int NUM_GROUPS      = 16,
    parameter int LOOPS_PER_GROUP = 8,
    parameter int NUM_BATCHES     = 10,
    parameter int CH_W            = 8,
    parameter int IDX_W           = 12
) (
    input logic          clk,
    input logic          reset,
    comp_seq_gen_if.slave bus
);
    localparam int STRIDE = batch_stride(NUM_GROUPS, LOOPS_PER_GROUP);
    localparam int G_W    = clog2_min1(NUM_GROUPS);
    localparam int K_W    = clog2_min1(NUM_BATCHES);
    localparam int L_W    = clog2_min1(LOOPS_PER_GROUP);

    if ((64'd1 << IDX_W) < 64'(NUM_GROUPS * LOOPS_PER_GROUP * NUM_BATCHES)) begin : g_idx_w_chk
        $error("IDX_W too narrow for NUM_GROUPS*LOOPS_PER_GROUP*NUM_BATCHES");
    end
    if ((64'd1 << CH_W) < 64'(num_pairs(NUM_GROUPS))) begin : g_ch_w_chk
        $error("CH_W too narrow for the number of group pairs");
    end

    state_t           r_state, w_state_nxt;
    logic [G_W-1:0]   r_gi, r_gj, w_i, w_j, w_g_nxt;
    logic [K_W-1:0]   r_k, w_k_nxt;
    logic [L_W-1:0]   r_l, w_l_nxt;
    logic             r_phase, r_valid, r_last, r_done;
    logic [IDX_W-1:0] r_idx;
    logic             w_start_req, w_load, w_hit, w_err, w_accept, w_ph_nxt, w_last_nxt;

    assign w_start_req = bus.start && (r_state == IDLE);
    assign w_accept    = r_valid && bus.tero_ready;

    comp_pair_decode #(
        .NUM_GROUPS (NUM_GROUPS),
        .CH_W       (CH_W),
        .G_W        (G_W)
    ) u_decode (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_start_req),
        .i_challenge (bus.challenge_in),
        .i_step      (r_state == DECODE),
        .o_load      (w_load),
        .o_hit       (w_hit),
        .o_err       (w_err),
        .o_i         (w_i),
        .o_j         (w_j)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_nxt = DECODE;
            DECODE:  if (w_hit) w_state_nxt = EMIT;
            EMIT:    if (w_accept && r_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Position of the beat that follows the one currently presented.
    always_comb begin
        w_k_nxt  = r_k;
        w_l_nxt  = r_l;
        w_ph_nxt = r_phase;
`ifdef COMP_SEQ_INTERLEAVE_EN
        if (!r_phase) begin
            w_ph_nxt = 1'b1;
        end else begin
            w_ph_nxt = 1'b0;
            if (r_k == K_W'(NUM_BATCHES - 1)) begin
                w_k_nxt = '0;
                w_l_nxt = (r_l == L_W'(LOOPS_PER_GROUP - 1)) ? '0 : r_l + L_W'(1);
            end else begin
                w_k_nxt = r_k + K_W'(1);
            end
        end
`else
        if (r_k == K_W'(NUM_BATCHES - 1)) begin
            w_k_nxt = '0;
            if (r_l == L_W'(LOOPS_PER_GROUP - 1)) begin
                w_l_nxt  = '0;
                w_ph_nxt = 1'b1;
            end else begin
                w_l_nxt = r_l + L_W'(1);
            end
        end else begin
            w_k_nxt = r_k + K_W'(1);
        end
`endif
        w_g_nxt    = w_ph_nxt ? r_gj : r_gi;
        w_last_nxt = w_ph_nxt && (w_k_nxt == K_W'(NUM_BATCHES - 1))
                     && (w_l_nxt == L_W'(LOOPS_PER_GROUP - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gi    <= '0;
            r_gj    <= '0;
            r_k     <= '0;
            r_l     <= '0;
            r_phase <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == DECODE && w_hit) begin
                r_gi    <= w_i;
                r_gj    <= w_j;
                r_k     <= '0;
                r_l     <= '0;
                r_phase <= 1'b0;
                r_valid <= 1'b1;
                r_last  <= 1'b0;
                r_idx   <= IDX_W'(tero_index(32'(w_i), 0, 0, STRIDE, LOOPS_PER_GROUP));
            end else if (r_state == EMIT && w_accept) begin
                if (r_last) begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_phase <= 1'b0;
                    r_idx   <= '0;
                    r_done  <= 1'b1;
                end else begin
                    r_k     <= w_k_nxt;
                    r_l     <= w_l_nxt;
                    r_phase <= w_ph_nxt;
                    r_last  <= w_last_nxt;
                    r_idx   <= IDX_W'(tero_index(32'(w_g_nxt), 32'(w_k_nxt), 32'(w_l_nxt),
                                                 STRIDE, LOOPS_PER_GROUP));
                end
            end
        end
    end

    assign bus.tero_idx   = r_idx;
    assign bus.tero_valid = r_valid;
    assign bus.tero_last  = r_last;
    assign bus.phase      = r_phase;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
    assign bus.err        = w_err;
endmodule

// File: tb/tb_comp_seq_gen.sv
// Randomised bench for comp_seq_gen against a pair-enumeration / beat-list reference model.
module tb_comp_seq_gen;
    import comp_seq_pkg::*;

    localparam int G     = 16;
    localparam int L     = 8;
    localparam int B     = 10;
    localparam int CH_W  = 8;
    localparam int IDX_W = 12;
    localparam int NP    = G * (G - 1) / 2;
    localparam int TOTAL = 2 * L * B;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int exp_idx[$];
    bit exp_ph[$];
    bit exp_last[$];

    always #5 clk = ~clk;

    comp_seq_gen_if #(.CH_W(CH_W), .IDX_W(IDX_W)) bus ();

    comp_seq_gen #(
        .NUM_GROUPS      (G),
        .LOOPS_PER_GROUP (L),
        .NUM_BATCHES     (B),
        .CH_W            (CH_W),
        .IDX_W           (IDX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Pair n in lexicographic order of all (a,b) with a<b.
    task automatic ref_pair(input int ch, output int pi, output int pj);
        int n = 0;
        pi = -1;
        pj = -1;
        for (int a = 0; a < G; a++)
            for (int b = a + 1; b < G; b++) begin
                if (n == ch) begin
                    pi = a;
                    pj = b;
                end
                n++;
            end
    endtask

    task automatic build_expect(input int pi, input int pj);
        exp_idx.delete();
        exp_ph.delete();
        exp_last.delete();
`ifdef COMP_SEQ_INTERLEAVE_EN
        for (int l = 0; l < L; l++)
            for (int k = 0; k < B; k++)
                for (int ph = 0; ph < 2; ph++) begin
                    exp_idx.push_back(((ph == 0 ? pi : pj) * L + k * G * L + l) % (1 << IDX_W));
                    exp_ph.push_back(ph == 1);
                    exp_last.push_back(ph == 1 && k == B - 1 && l == L - 1);
                end
`else
        for (int ph = 0; ph < 2; ph++)
            for (int l = 0; l < L; l++)
                for (int k = 0; k < B; k++) begin
                    exp_idx.push_back(((ph == 0 ? pi : pj) * L + k * G * L + l) % (1 << IDX_W));
                    exp_ph.push_back(ph == 1);
                    exp_last.push_back(ph == 1 && k == B - 1 && l == L - 1);
                end
`endif
    endtask

    task automatic run_seq(input int ch, input int ready_pct, input int stall_beat,
                           input int abort_beat, input int next_ch, input bit prestarted);
        int pi, pj, beat, cyc, first_valid, stall_cnt;
        bit prev_stall, saw_done;
        logic [IDX_W-1:0] held, exp_i;
        ref_pair(ch, pi, pj);
        build_expect(pi, pj);
        if (!prestarted) begin
            @(negedge clk);
            bus.start        = 1'b1;
            bus.challenge_in = CH_W'(ch);
        end
        @(negedge clk);
        bus.start        = 1'b0;
        bus.challenge_in = CH_W'($urandom_range(NP - 1));
        beat = 0; cyc = 1; first_valid = -1; stall_cnt = 0;
        prev_stall = 1'b0; saw_done = 1'b0; held = '0;
        while (cyc < 2000 && !saw_done) begin
            if (bus.done) begin
                saw_done = 1'b1;
                checks++;
                if (beat != TOTAL || bus.tero_valid !== 1'b0 || bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_state ch=%0d: beats=%0d valid=%b busy=%b, expected beats=%0d valid=0 busy=0",
                             ch, beat, bus.tero_valid, bus.busy, TOTAL);
                end
                bus.start = (next_ch >= 0);
                if (next_ch >= 0) bus.challenge_in = CH_W'(next_ch);
            end else begin
                checks++;
                if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_err ch=%0d cyc=%0d: busy=%b err=%b, expected busy=1 err=0",
                             ch, cyc, bus.busy, bus.err);
                end
                if (bus.tero_valid) begin
                    if (first_valid < 0) begin
                        first_valid = cyc;
                        checks++;
                        if (cyc != pi + 2) begin
                            errors++;
                            $display("FAIL decode_latency ch=%0d: first valid at cycle %0d, expected %0d",
                                     ch, cyc, pi + 2);
                        end
                    end
                    if (prev_stall) begin
                        checks++;
                        if (bus.tero_idx !== held) begin
                            errors++;
                            $display("FAIL hold ch=%0d beat=%0d: idx=%0d, expected held %0d",
                                     ch, beat, bus.tero_idx, held);
                        end
                    end
                    if (beat == abort_beat) begin
                        reset = 1'b1;
                        bus.start = 1'b0;
                        bus.tero_ready = 1'b0;
                        #1;
                        checks++;
                        if ({bus.tero_idx, bus.tero_valid, bus.tero_last, bus.phase,
                             bus.busy, bus.done, bus.err} !== '0) begin
                            errors++;
                            $display("FAIL reset_abort: idx=%0d valid=%b last=%b phase=%b busy=%b done=%b err=%b, expected all 0",
                                     bus.tero_idx, bus.tero_valid, bus.tero_last, bus.phase,
                                     bus.busy, bus.done, bus.err);
                        end
                        repeat (3) begin
                            @(negedge clk);
                            checks++;
                            if (bus.done !== 1'b0 || bus.tero_valid !== 1'b0) begin
                                errors++;
                                $display("FAIL reset_hold: done=%b valid=%b, expected 0 0",
                                         bus.done, bus.tero_valid);
                            end
                        end
                        reset = 1'b0;
                        return;
                    end
                    if (beat == stall_beat && stall_cnt < 3) begin
                        bus.tero_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        bus.tero_ready = ($urandom_range(99) < ready_pct);
                    end
                    if (bus.tero_ready) begin
                        checks++;
                        if (beat >= TOTAL) begin
                            errors++;
                            $display("FAIL extra_beat ch=%0d: beat %0d idx=%0d, expected only %0d beats",
                                     ch, beat, bus.tero_idx, TOTAL);
                        end else begin
                            exp_i = IDX_W'(exp_idx[beat]);
                            if (bus.tero_idx !== exp_i || bus.phase !== exp_ph[beat] ||
                                bus.tero_last !== exp_last[beat]) begin
                                errors++;
                                $display("FAIL beat ch=%0d #%0d: idx=%0d phase=%b last=%b, expected idx=%0d phase=%b last=%b",
                                         ch, beat, bus.tero_idx, bus.phase, bus.tero_last,
                                         exp_i, exp_ph[beat], exp_last[beat]);
                            end
                        end
                        beat++;
                    end
                    prev_stall = !bus.tero_ready;
                    held       = bus.tero_idx;
                end else begin
                    prev_stall     = 1'b0;
                    bus.tero_ready = 1'($urandom_range(1));
                end
                // Requests while busy must be ignored.
                bus.start        = 1'($urandom_range(1));
                bus.challenge_in = CH_W'($urandom);
                @(negedge clk);
                cyc++;
            end
        end
        if (!saw_done) begin
            checks++;
            errors++;
            bus.start = 1'b0;
            $display("FAIL timeout ch=%0d: no done after %0d cycles, beats=%0d expected %0d",
                     ch, cyc, beat, TOTAL);
        end else if (next_ch < 0) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL done_width ch=%0d: done=%b one cycle later, expected 0", ch, bus.done);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.challenge_in = '0;
        bus.tero_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.tero_idx, bus.tero_valid, bus.tero_last, bus.phase,
             bus.busy, bus.done, bus.err} !== '0) begin
            errors++;
            $display("FAIL reset_state: idx=%0d valid=%b last=%b phase=%b busy=%b done=%b err=%b, expected all 0",
                     bus.tero_idx, bus.tero_valid, bus.tero_last, bus.phase, bus.busy, bus.done, bus.err);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.tero_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: busy=%b valid=%b, expected 0 0", bus.busy, bus.tero_valid);
        end
    endtask

    task automatic test_invalid(input int ch);
        @(negedge clk);
        bus.start = 1'b1;
        bus.challenge_in = CH_W'(ch);
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.tero_valid !== 1'b0) begin
            errors++;
            $display("FAIL invalid_err ch=%0d: err=%b busy=%b valid=%b, expected 1 0 0",
                     ch, bus.err, bus.busy, bus.tero_valid);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.tero_valid !== 1'b0) begin
                errors++;
                $display("FAIL invalid_after ch=%0d: err=%b busy=%b valid=%b, expected 0 0 0",
                         ch, bus.err, bus.busy, bus.tero_valid);
            end
        end
    endtask

    task automatic test_main();
        run_seq(14, 100, -1, -1, -1, 1'b0);
        run_seq(15, 100, -1, -1, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_seq(0, 100, 4, -1, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_seq(int'($urandom_range(NP - 1)), 100, -1, 40, -1, 1'b0);
        run_seq(119, 100, -1, -1, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++)
            run_seq(int'($urandom_range(NP - 1)), 60, -1, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int a, b;
        a = int'($urandom_range(NP - 1));
        b = int'($urandom_range(NP - 1));
        run_seq(a, 100, -1, -1, b, 1'b0);
        run_seq(b, 70, -1, -1, -1, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_main();
        test_invalid(NP);
        test_invalid(255);
        test_invalid(int'($urandom_range(255, NP)));
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
